// File: rtl/otg_hpi_master_if.sv
// Avalon-MM slave-side bus between the Nios II and the HPI sequencer.
// The master modport is the Avalon initiator; slave is the sequencer.
interface otg_hpi_master_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/otg_hpi_master.sv
// CY7C67200 HPI bus sequencer: one timed HPI cycle per Avalon access.
// Optional interrupt synchronizer enabled by defining OTG_HPI_IRQ_EN.
module otg_hpi_master #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        reset,
    otg_hpi_master_if.slave bus,
    output logic [1:0]  otg_hpi_address,
    input  logic [15:0] otg_hpi_data_in,
    output logic [15:0] otg_hpi_data_out,
    output logic        otg_hpi_data_oe,
    output logic        otg_hpi_cs_n,
    output logic        otg_hpi_r_n,
    output logic        otg_hpi_w_n,
    input  logic        otg_hpi_int,
    output logic        irq
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic        is_wr;
    logic [15:0] rdata;
    logic        waitreq;

    assign bus.readdata    = {16'h0000, rdata};
    assign bus.waitrequest = waitreq;

    // Pins are set on the transition into each state so every output is a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= 8'd0;
            is_wr            <= 1'b0;
            rdata            <= 16'h0000;
            waitreq          <= 1'b1;
            otg_hpi_address  <= 2'd0;
            otg_hpi_data_out <= 16'h0000;
            otg_hpi_data_oe  <= 1'b0;
            otg_hpi_cs_n     <= 1'b1;
            otg_hpi_r_n      <= 1'b1;
            otg_hpi_w_n      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.chipselect && (!bus.read_n || !bus.write_n)) begin
                        state           <= SETUP;
                        cnt             <= 8'(SETUP_CYCLES - 1);
                        is_wr           <= !bus.write_n;
                        otg_hpi_address <= bus.address;
                        otg_hpi_cs_n    <= 1'b0;
                        otg_hpi_data_oe <= !bus.write_n;
                        if (!bus.write_n)
                            otg_hpi_data_out <= bus.writedata[15:0];
                    end
                end
                SETUP: begin
                    if (cnt == 8'd0) begin
                        state       <= STROBE;
                        cnt         <= 8'(STROBE_CYCLES - 1);
                        otg_hpi_r_n <= is_wr;
                        otg_hpi_w_n <= !is_wr;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                STROBE: begin
                    if (cnt == 8'd0) begin
                        state       <= HOLD;
                        cnt         <= 8'(HOLD_CYCLES - 1);
                        otg_hpi_r_n <= 1'b1;
                        otg_hpi_w_n <= 1'b1;
                        if (!is_wr)
                            rdata <= otg_hpi_data_in;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 8'd0) begin
                        state           <= DONE;
                        otg_hpi_cs_n    <= 1'b1;
                        otg_hpi_data_oe <= 1'b0;
                        waitreq         <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DONE: begin
                    // The request still visible here is the one just completed.
                    state   <= IDLE;
                    waitreq <= 1'b1;
                end
                default: begin
                    state           <= IDLE;
                    waitreq         <= 1'b1;
                    otg_hpi_cs_n    <= 1'b1;
                    otg_hpi_r_n     <= 1'b1;
                    otg_hpi_w_n     <= 1'b1;
                    otg_hpi_data_oe <= 1'b0;
                end
            endcase
        end
    end

`ifdef OTG_HPI_IRQ_EN
    logic [1:0] int_sync;

    always_ff @(posedge clk) begin
        if (reset) int_sync <= 2'b00;
        else       int_sync <= {int_sync[0], otg_hpi_int};
    end

    assign irq = int_sync[1];

    logic unused_ok;
    assign unused_ok = ^bus.writedata[31:16];
`else
    assign irq = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{bus.writedata[31:16], otg_hpi_int};
`endif
endmodule

// File: tb/tb_otg_hpi_master.sv
// Scoreboard bench for otg_hpi_master: default-timing DUT plus a short-timing DUT.
module tb_otg_hpi_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    otg_hpi_master_if bus0();
    otg_hpi_master_if bus1();

    logic [1:0]  a0, a1;
    logic [15:0] din0, dout0, din1, dout1, pin_val;
    logic        oe0, cs0, r0, w0, irq0;
    logic        oe1, cs1, r1, w1, irq1;
    logic        int_pin;

    // The chip only drives valid read data while the read strobe is low.
    assign din0 = r0 ? 16'hDEAD : pin_val;
    assign din1 = 16'h0000;

    otg_hpi_master u0 (
        .clk(clk), .reset(reset), .bus(bus0.slave),
        .otg_hpi_address(a0), .otg_hpi_data_in(din0), .otg_hpi_data_out(dout0),
        .otg_hpi_data_oe(oe0), .otg_hpi_cs_n(cs0), .otg_hpi_r_n(r0), .otg_hpi_w_n(w0),
        .otg_hpi_int(int_pin), .irq(irq0)
    );

    otg_hpi_master #(.SETUP_CYCLES(3), .STROBE_CYCLES(1), .HOLD_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .bus(bus1.slave),
        .otg_hpi_address(a1), .otg_hpi_data_in(din1), .otg_hpi_data_out(dout1),
        .otg_hpi_data_oe(oe1), .otg_hpi_cs_n(cs1), .otg_hpi_r_n(r1), .otg_hpi_w_n(w1),
        .otg_hpi_int(int_pin), .irq(irq1)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_bus();
        bus0.chipselect = 1'b0; bus0.read_n = 1'b1; bus0.write_n = 1'b1;
        bus0.address = 2'd0; bus0.writedata = 32'h0;
        bus1.chipselect = 1'b0; bus1.read_n = 1'b1; bus1.write_n = 1'b1;
        bus1.address = 2'd0; bus1.writedata = 32'h0;
    endtask

    // Drives one request on DUT0 and watches it until waitrequest drops.
    task automatic run_txn(input bit wr, input logic [1:0] a, input logic [15:0] wd,
                           output int done_cyc, output int cs_lo, output int stb_lo,
                           output int pre_hi, output int bad_pins);
        bit seen = 0;
        bus0.chipselect = 1'b1; bus0.address = a; bus0.writedata = {16'hA5A5, wd};
        bus0.read_n = wr; bus0.write_n = !wr;
        if (!wr) exp_q.push_back({16'h0000, pin_val});
        done_cyc = 0; cs_lo = 0; stb_lo = 0; pre_hi = 0; bad_pins = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (cs0 == 1'b0) begin
                cs_lo++; seen = 1;
                if (a0 !== a || oe0 !== wr || (wr && dout0 !== wd)) bad_pins++;
            end else begin
                if (!seen) pre_hi++;
                if (oe0 !== 1'b0) bad_pins++;
            end
            if (wr ? (w0 == 1'b0) : (r0 == 1'b0)) stb_lo++;
            if (wr ? (r0 == 1'b0) : (w0 == 1'b0)) bad_pins++;
            if (bus0.waitrequest == 1'b0) begin
                done_cyc = k;
                break;
            end
        end
        total++;
        if (done_cyc == 0) begin
            bad++;
            $display("FAIL txn_timeout: waitrequest never low within 40 cycles");
        end else if (!wr) begin
            logic [31:0] e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            if (bus0.readdata !== e) begin
                bad++;
                $display("FAIL readdata: got %h want %h", bus0.readdata, e);
            end
        end
    endtask

    task automatic test_reset();
        total++;
        if (cs0 !== 1'b1 || r0 !== 1'b1 || w0 !== 1'b1 || oe0 !== 1'b0 || a0 !== 2'd0 ||
            dout0 !== 16'h0 || bus0.readdata !== 32'h0 || bus0.waitrequest !== 1'b1 || irq0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: cs=%b r=%b w=%b oe=%b a=%0d dout=%h rd=%h wr=%b irq=%b want 1 1 1 0 0 0000 0 1 0",
                     cs0, r0, w0, oe0, a0, dout0, bus0.readdata, bus0.waitrequest, irq0);
        end
    endtask

    task automatic test_write();
        int d, c, s, p, b;
        run_txn(1'b1, 2'd2, 16'h1234, d, c, s, p, b);
        total++; if (d !== 8) begin bad++; $display("FAIL wr_latency: got %0d want 8", d); end
        total++; if (c !== 7) begin bad++; $display("FAIL wr_cs_low: got %0d want 7", c); end
        total++; if (s !== 4) begin bad++; $display("FAIL wr_strobe: got %0d want 4", s); end
        total++; if (b !== 0) begin bad++; $display("FAIL wr_pins: got %0d bad cycles want 0", b); end
        idle_bus();
        step();
        total++;
        if (bus0.waitrequest !== 1'b1 || cs0 !== 1'b1) begin
            bad++;
            $display("FAIL wr_wait_one: waitrequest=%b cs=%b want 1 1", bus0.waitrequest, cs0);
        end
    endtask

    task automatic test_read();
        int d, c, s, p, b;
        pin_val = 16'hBEEF;
        run_txn(1'b0, 2'd0, 16'h0, d, c, s, p, b);
        total++; if (d !== 8) begin bad++; $display("FAIL rd_latency: got %0d want 8", d); end
        total++; if (s !== 4) begin bad++; $display("FAIL rd_strobe: got %0d want 4", s); end
        total++; if (b !== 0) begin bad++; $display("FAIL rd_pins: got %0d bad cycles want 0", b); end
        idle_bus();
        step();
    endtask

    task automatic test_back_to_back();
        int d, c, s, p, b;
        run_txn(1'b1, 2'd1, 16'h5678, d, c, s, p, b);
        total++; if (d !== 8 || b !== 0) begin bad++; $display("FAIL b2b_first: lat=%0d bad=%0d want 8 0", d, b); end
        pin_val = 16'h1357;
        run_txn(1'b0, 2'd3, 16'h0, d, c, s, p, b);
        total++; if (p + 1 !== 2) begin bad++; $display("FAIL b2b_cs_gap: got %0d want 2", p + 1); end
        total++; if (d !== 9) begin bad++; $display("FAIL b2b_latency: got %0d want 9", d); end
        total++; if (b !== 0 || s !== 4) begin bad++; $display("FAIL b2b_second: bad=%0d strobe=%0d want 0 4", b, s); end
        idle_bus();
        step();
        run_txn(1'b1, 2'd0, 16'h9999, d, c, s, p, b);
        idle_bus();
        total++;
        if (bus0.readdata !== 32'h0000_1357) begin
            bad++;
            $display("FAIL rd_stable: got %h want 00001357", bus0.readdata);
        end
        step();
    endtask

    task automatic test_reset_mid_strobe();
        int d, c, s, p, b;
        bit hit = 0;
        bus0.chipselect = 1'b1; bus0.address = 2'd2; bus0.writedata = 32'h0000_CAFE;
        bus0.read_n = 1'b1; bus0.write_n = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (w0 == 1'b0) begin hit = 1; break; end
        end
        step();
        reset = 1'b1;
        idle_bus();
        step();
        reset = 1'b0;
        total++;
        if (!hit || w0 !== 1'b1 || cs0 !== 1'b1 || oe0 !== 1'b0 || bus0.waitrequest !== 1'b1) begin
            bad++;
            $display("FAIL rst_strobe: hit=%b w=%b cs=%b oe=%b wait=%b want 1 1 1 0 1", hit, w0, cs0, oe0, bus0.waitrequest);
        end
        pin_val = 16'h4242;
        run_txn(1'b0, 2'd1, 16'h0, d, c, s, p, b);
        total++; if (d !== 8 || b !== 0 || s !== 4) begin bad++; $display("FAIL rst_recover: lat=%0d bad=%0d strobe=%0d want 8 0 4", d, b, s); end
        idle_bus();
        step();
    endtask

    task automatic test_params();
        int d = 0, s = 0;
        bus1.chipselect = 1'b1; bus1.address = 2'd3; bus1.writedata = 32'h0000_0F0F;
        bus1.read_n = 1'b1; bus1.write_n = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (w1 == 1'b0) s++;
            if (bus1.waitrequest == 1'b0) begin d = k; break; end
        end
        idle_bus();
        total++; if (s !== 1) begin bad++; $display("FAIL par_strobe: got %0d want 1", s); end
        total++; if (d !== 6) begin bad++; $display("FAIL par_latency: got %0d want 6", d); end
        step();
    endtask

    task automatic test_irq();
        int lat = 0;
        int_pin = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
`ifdef OTG_HPI_IRQ_EN
            if (irq0 == 1'b1) begin lat = k; break; end
`else
            if (irq0 !== 1'b0) lat = k;
`endif
        end
`ifdef OTG_HPI_IRQ_EN
        total++; if (lat < 1 || lat > 3) begin bad++; $display("FAIL irq_rise: latency %0d want 1..3", lat); end
        int_pin = 1'b0;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (irq0 == 1'b0) begin lat = k; break; end
        end
        total++; if (lat < 1 || lat > 3) begin bad++; $display("FAIL irq_fall: latency %0d want 1..3", lat); end
`else
        total++; if (lat !== 0) begin bad++; $display("FAIL irq_tied: irq high at cycle %0d want never", lat); end
        int_pin = 1'b0;
`endif
    endtask

    initial begin
        reset = 1'b1;
        int_pin = 1'b0;
        pin_val = 16'h0000;
        idle_bus();
        repeat (3) step();
        test_reset();
        reset = 1'b0;
        step();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid_strobe();
        test_params();
        test_irq();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/otg_hpi_master.md
# otg_hpi_master

Hardware sequencer for the CY7C67200 Host Port Interface (HPI), acting as bus initiator on the HPI pins. It is an Avalon-MM slave with waitrequest on the Nios II side: each Avalon read or write is converted into one timed HPI bus cycle (address, chip select, read/write strobes, 16-bit data). It replaces the per-pin PIO bit-banging of the HPI address, data, cs, r and w lines and serves the USB keyboard driver.

## Interface
Parameters:
- SETUP_CYCLES, 1: cycles with cs_n low and address/data valid before the strobe asserts; legal 1..255.
- STROBE_CYCLES, 4: strobe (r_n or w_n) low width in cycles; legal 1..255.
- HOLD_CYCLES, 2: cycles after strobe release with cs_n, address and write data held; legal 1..255.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  Avalon word address; passed to the HPI address pins (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS).
- chipselect  in  1  Avalon select.
- read_n  in  1  Avalon read, active low.
- write_n  in  1  Avalon write, active low.
- writedata  in  32  write data; bits [15:0] used.
- readdata  out  32  {16'b0, captured HPI data}.
- waitrequest  out  1  Avalon stall; low for exactly one cycle at completion.
- otg_hpi_address  out  2  HPI address pins.
- otg_hpi_data_in  in  16  HPI data from the tristate pad.
- otg_hpi_data_out  out  16  HPI data to the tristate pad.
- otg_hpi_data_oe  out  1  pad output enable.
- otg_hpi_cs_n  out  1  HPI chip select, active low.
- otg_hpi_r_n  out  1  HPI read strobe, active low.
- otg_hpi_w_n  out  1  HPI write strobe, active low.
- otg_hpi_int  in  1  HPI interrupt from the chip, asynchronous.
- irq  out  1  interrupt to the Nios II.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, DONE. An 8-bit down-counter times SETUP, STROBE and HOLD.
- IDLE: if chipselect && (~read_n || ~write_n), latch address, the direction (write wins if both are low) and writedata[15:0], then go to SETUP with the counter loaded to SETUP_CYCLES-1.
- SETUP: cs_n=0. For writes, data_oe=1. When the counter reaches 0, go to STROBE.
- STROBE: cs_n=0 and r_n=0 (read) or w_n=0 (write). On the last STROBE cycle, register otg_hpi_data_in into the readdata holding register (reads only). Then go to HOLD.
- HOLD: cs_n=0, strobes high, address held. For writes, data_oe=1. Then go to DONE.
- DONE: cs_n=1, waitrequest=0 for one cycle, then go to IDLE.
- waitrequest = (state != DONE).
- The Avalon master holds its request stable while waitrequest=1. The request visible during DONE is the one being completed and is not re-accepted.
- otg_hpi_address, otg_hpi_data_out and readdata are registered and keep their last value between transactions.
- Deselect or a change of request mid-transaction is ignored. The latched transaction runs to completion.
- Reset in any state: next cycle is IDLE with all pins deasserted. A partial HPI cycle is abandoned; the strobe is released immediately.

## Timing
- Reset values: cs_n=1, r_n=1, w_n=1, data_oe=0, otg_hpi_address=0, otg_hpi_data_out=0, readdata=0, waitrequest=1, irq=0.
- All outputs are registered or decoded from the state register only; there is no combinational path from Avalon inputs to pins.
- Latency: a request first seen in IDLE at cycle 0 is in SETUP at cycle 1. waitrequest goes low at cycle 1+SETUP+STROBE+HOLD (defaults: cycle 8).
- Strobe low width is exactly STROBE_CYCLES. Address setup to strobe is SETUP_CYCLES. Address/data hold after strobe release is HOLD_CYCLES.
- cs_n is high for at least 2 cycles (DONE + IDLE) between back-to-back transactions.
- readdata is valid in the DONE cycle and stays stable until the next read completes.

## Configuration
- OTG_HPI_IRQ_EN defined:
  - otg_hpi_int passes through a 2-flop synchronizer.
  - irq is the synchronized level, active high, 2–3 cycles of latency.
  - irq is 0 during reset.
- OTG_HPI_IRQ_EN undefined: irq tied to 0; no synchronizer flops are built.

## Test plan
- Write with defaults, address=2, writedata=0x1234:
  - cs_n low for 7 cycles, w_n low for exactly 4 cycles.
  - otg_hpi_address=2 and data_out=0x1234 with data_oe=1 from SETUP through HOLD.
  - waitrequest low for exactly one cycle, at cycle 8.
- Read, address=0, with otg_hpi_data_in=0xBEEF during STROBE:
  - r_n low for 4 cycles, data_oe=0 throughout.
  - readdata=0x0000BEEF when waitrequest=0.
- Back-to-back write then read (master re-requests immediately):
  - cs_n high for exactly 2 cycles between the two accesses.
  - Second access uses the new address and direction.
- Assert reset during STROBE of a write:
  - Next cycle w_n=1, cs_n=1, data_oe=0, waitrequest=1, state IDLE.
  - A following read completes normally.
- Parameters SETUP=3, STROBE=1, HOLD=1: strobe low for 1 cycle, waitrequest low at cycle 6.
- With OTG_HPI_IRQ_EN, toggle otg_hpi_int: irq follows within 3 cycles. Without the macro: irq stays 0.
